// File: rtl/and_gate_pipe.sv
// rtl/and_gate_pipe.sv - registered WIDTH-bit logic unit with accumulator, valid/ready handshake; optional AND_GATE_CNT_EN output-fire counter
module and_gate_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] n,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o,
  output logic             o_all,
  output logic             o_any,
  output logic             out_valid,
  input  logic             out_ready
`ifdef AND_GATE_CNT_EN
  ,
  output logic [15:0]      txn_cnt
`endif
);

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_NAND    = 3'b011;
  localparam logic [2:0] OP_NOR     = 3'b100;
  localparam logic [2:0] OP_XNOR    = 3'b101;
  localparam logic [2:0] OP_ACC_AND = 3'b110;
  localparam logic [2:0] OP_ACC_CLR = 3'b111;

  logic             out_valid_q;
  logic [WIDTH-1:0] o_q;
  logic             o_all_q;
  logic             o_any_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] acc_d;
  logic             in_fire;
  logic             out_fire;

  // The single output register frees up whenever it is empty or being drained.
  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign o_all     = o_all_q;
  assign o_any     = o_any_q;

  // Result and accumulator candidate for the operands currently presented.
  always_comb begin
    res_d = '0;
    acc_d = acc_q;
    case (op)
      OP_AND:     res_d = m & n;
      OP_OR:      res_d = m | n;
      OP_XOR:     res_d = m ^ n;
      OP_NAND:    res_d = ~(m & n);
      OP_NOR:     res_d = ~(m | n);
      OP_XNOR:    res_d = ~(m ^ n);
      OP_ACC_AND: begin
        acc_d = acc_q & m & n;
        res_d = acc_d;
      end
      OP_ACC_CLR: begin
        acc_d = ACC_INIT;
        res_d = ACC_INIT;
      end
      default:    res_d = '0;
    endcase
  end

  // Output register, reductions and accumulator; everything moves only on an input fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      o_q         <= '0;
      o_all_q     <= 1'b0;
      o_any_q     <= 1'b0;
      acc_q       <= ACC_INIT;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      o_q         <= res_d;
      o_all_q     <= &res_d;
      o_any_q     <= |res_d;
      acc_q       <= acc_d;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef AND_GATE_CNT_EN
  logic [15:0] cnt_q;

  assign txn_cnt = cnt_q;

  // Free-running count of accepted results, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (out_fire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_and_gate_pipe.sv
// tb/tb_and_gate_pipe.sv - self-checking bench for and_gate_pipe (WIDTH=8)
module tb_and_gate_pipe;

  logic       clk;
  logic       rst;
  logic [7:0] m;
  logic [7:0] n;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] o;
  logic       o_all;
  logic       o_any;
  logic       out_valid;
  logic       out_ready;
`ifdef AND_GATE_CNT_EN
  logic [15:0] txn_cnt;
`endif

  and_gate_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .m         (m),
    .n         (n),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o         (o),
    .o_all     (o_all),
    .o_any     (o_any),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef AND_GATE_CNT_EN
    ,
    .txn_cnt   (txn_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          known = 0;
  bit          mv;
  logic [7:0]  mo;
  logic [7:0]  macc;
  logic [15:0] mcnt;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_o;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model, return at next posedge+1.
  task automatic tick(input logic r, input logic iv, input logic [2:0] opx,
                      input logic [7:0] a, input logic [7:0] b, input logic ordy);
    bit exp_ir, in_f, out_f;
    rst = r; in_valid = iv; op = opx; m = a; n = b; out_ready = ordy;
    @(negedge clk);
    if (known) begin
      exp_ir = !mv || ordy;
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("o", 64'(o), 64'(mo));
      chk("o_all", 64'(o_all), 64'(mo == 8'hFF));
      chk("o_any", 64'(o_any), 64'(mo != 8'h00));
`ifdef AND_GATE_CNT_EN
      chk("txn_cnt", 64'(txn_cnt), 64'(mcnt));
`endif
    end
    if (r) begin
      known = 1; mv = 0; mo = 8'h00; macc = 8'hFF; mcnt = 16'd0;
    end else if (known) begin
      exp_ir = !mv || ordy;
      in_f   = iv && exp_ir;
      out_f  = mv && ordy;
      if (out_f) mcnt = mcnt + 16'd1;
      if (in_f) begin
        mv = 1;
        case (opx)
          3'd0: mo = a & b;
          3'd1: mo = a | b;
          3'd2: mo = a ^ b;
          3'd3: mo = ~(a & b);
          3'd4: mo = ~(a | b);
          3'd5: mo = ~(a ^ b);
          3'd6: begin macc = macc & a & b; mo = macc; end
          default: begin macc = 8'hFF; mo = 8'hFF; end
        endcase
      end else if (out_f) begin
        mv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    rst = 1; in_valid = 0; op = 0; m = 0; n = 0; out_ready = 0;
    #1;

    vecs[0]  = '{3'd0, 8'hF0, 8'hCC, 8'hC0};
    vecs[1]  = '{3'd1, 8'hF0, 8'hCC, 8'hFC};
    vecs[2]  = '{3'd2, 8'hF0, 8'hCC, 8'h3C};
    vecs[3]  = '{3'd3, 8'hF0, 8'hCC, 8'h3F};
    vecs[4]  = '{3'd4, 8'hF0, 8'hCC, 8'h03};
    vecs[5]  = '{3'd5, 8'hF0, 8'hCC, 8'hC3};
    vecs[6]  = '{3'd7, 8'h12, 8'h34, 8'hFF};
    vecs[7]  = '{3'd6, 8'hFE, 8'hFF, 8'hFE};
    vecs[8]  = '{3'd6, 8'hFF, 8'h7F, 8'h7E};
    vecs[9]  = '{3'd0, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{3'd6, 8'hFF, 8'hFF, 8'h7E};

    // Reset held two cycles with in_valid high
    tick(1, 1, 3'd0, 8'hAA, 8'h55, 1);
    tick(1, 1, 3'd0, 8'hAA, 8'h55, 1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_o", 64'(o), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick(0, 1, 3'd6, 8'hFF, 8'hFF, 1);
    chk("rst_acc_init", 64'(o), 64'hFF);

    // All ops and accumulator sequence, back to back
    for (int i = 0; i < 11; i++) begin
      tick(0, 1, vecs[i].op, vecs[i].a, vecs[i].b, 1);
      chk($sformatf("vec%0d_o", i), 64'(o), 64'(vecs[i].exp_o));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      if (i == 0) begin
        chk("c0_all", 64'(o_all), 64'd0);
        chk("c0_any", 64'(o_any), 64'd1);
      end
    end

    // Backpressure: result 0x3C held while a new input waits
    tick(0, 1, 3'd2, 8'hF0, 8'hCC, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 3'd6, 8'h00, 8'h00, 0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_o", 64'(o), 64'h3C);
    end
    tick(0, 1, 3'd0, 8'h55, 8'h0F, 1);
    chk("bp_loaded", 64'(o), 64'h05);
    tick(0, 1, 3'd6, 8'hFF, 8'hFF, 1);
    chk("bp_acc_kept", 64'(o), 64'h7E);

    // Reset while a result is stalled
    tick(0, 1, 3'd1, 8'h0F, 8'h30, 1);
    tick(0, 0, 3'd0, 8'h00, 8'h00, 0);
    tick(1, 0, 3'd0, 8'h00, 8'h00, 0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
`ifdef AND_GATE_CNT_EN
    chk("midrst_cnt", 64'(txn_cnt), 64'd0);
`endif
    tick(0, 1, 3'd6, 8'hFF, 8'hFF, 1);
    chk("midrst_acc", 64'(o), 64'hFF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(49) == 0), ($urandom_range(3) != 0), 3'($urandom_range(7)),
           8'($urandom_range(255)), 8'($urandom_range(255)), ($urandom_range(2) != 0));
    end

`ifdef AND_GATE_CNT_EN
    // Counter wrap: 65537 output fires after a reset
    tick(1, 0, 3'd0, 8'h00, 8'h00, 1);
    for (int i = 0; i < 65537; i++) begin
      tick(0, 1, 3'($urandom_range(7)), 8'($urandom_range(255)), 8'($urandom_range(255)), 1);
    end
    tick(0, 0, 3'd0, 8'h00, 8'h00, 1);
    chk("cnt_wrap", 64'(txn_cnt), 64'd1);
    tick(0, 0, 3'd0, 8'h00, 8'h00, 0);
    chk("cnt_idle", 64'(txn_cnt), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/and_gate_pipe.md
Name: and_gate_pipe

Overview:
- Parametrised, registered successor to the 2-input AND gate.
- WIDTH-bit bitwise logic unit with selectable operation, a running-AND accumulator mode, and a valid/ready handshake on both sides.
- Sits between streaming producers and consumers in the datapath, where a bare combinational gate cannot absorb backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- ACC_INIT, all-ones of WIDTH, accumulator value after reset and after ACC_CLR.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- m  input  WIDTH  operand A.
- n  input  WIDTH  operand B.
- op  input  3  operation select, sampled with m and n.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept operands this cycle.
- o  output  WIDTH  registered result.
- o_all  output  1  AND-reduction of o.
- o_any  output  1  OR-reduction of o.
- out_valid  output  1  o, o_all and o_any are valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset is synchronous: rst high at a rising edge gives the following next state.
  - out_valid=0, o=0, o_all=0, o_any=0, accumulator=ACC_INIT.
  - in_ready is combinational and reads 1 immediately after reset.
- Reset mid-operation discards any held result with no output handshake. rst has priority over every other event in the same cycle.
- in_ready = !out_valid || out_ready, combinational. There is no combinational path from m, n or op to the outputs.
- An input fires on in_valid && in_ready. On the next edge, o is loaded with the op result and out_valid is set to 1.
- An output fires on out_valid && out_ready.
  - If an input also fires in the same cycle, the new result replaces the old one and out_valid stays 1. This gives back-to-back throughput of 1 per cycle.
  - If no input fires, out_valid goes to 0 and o holds its last value.
- When out_valid=1 and out_ready=0: o, o_all, o_any and the accumulator are frozen, and in_ready=0.
- Latency is 1 cycle from the input fire to out_valid.
- Op encoding (a=m, b=n):
  - 000 AND: a & b
  - 001 OR: a | b
  - 010 XOR: a ^ b
  - 011 NAND: ~(a & b)
  - 100 NOR: ~(a | b)
  - 101 XNOR: ~(a ^ b)
  - 110 ACC_AND: acc_next = acc & a & b; o = acc_next; acc <= acc_next
  - 111 ACC_CLR: acc <= ACC_INIT; o = ACC_INIT; m and n are ignored.
- The accumulator updates only on an input fire with op 110 or 111. Ops 000..101 leave it unchanged.
- o_all and o_any are registered together with o, so they are always consistent with o. With WIDTH=1, o_all = o_any = o.
- in_valid=1 while in_ready=0 is legal. The producer holds its data, and nothing is consumed.
- All arithmetic is bitwise on WIDTH bits, with no carries and no width extension.

Optional Feature:
- Macro AND_GATE_CNT_EN.
- When defined:
  - Adds an output port txn_cnt (16 bits) counting output fires.
  - The counter increments by 1 on each out_valid && out_ready and wraps from 0xFFFF to 0x0000.
  - Reset to 0 by rst.
- When undefined, the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset with WIDTH=8: hold rst 2 cycles with in_valid=1. Then out_valid=0, o=0x00, in_ready=1, and a following ACC_AND with m=n=0xFF gives o=0xFF, confirming acc=ACC_INIT.
- All ops with out_ready=1, m=0xF0, n=0xCC for ops 000..101 in consecutive cycles. Expect o = 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, with out_valid=1 each cycle and 1-cycle latency. For 0xC0, o_all=0 and o_any=1.
- Accumulator: ACC_CLR, then ACC_AND with (0xFE,0xFF), then (0xFF,0x7F). Expect o = 0xFF, 0xFE, 0x7E. A following AND op (0x00,0x00) gives o=0x00, and a later ACC_AND (0xFF,0xFF) gives 0x7E.
- Backpressure: load a result of 0x3C, then hold out_ready=0 for 3 cycles while in_valid=1 with new data. Expect in_ready=0, o stable at 0x3C, and no accumulator change. Then out_ready=1: 0x3C is accepted and the held input is loaded the next cycle.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0. The next cycle has out_valid=0, acc=0xFF, and txn_cnt=0 with AND_GATE_CNT_EN.
- Counter (AND_GATE_CNT_EN): perform 65537 back-to-back fires. Expect txn_cnt=1 after the wrap. Counter values are unchanged during stall cycles.
